// File: rtl/reg_file_mp_pkg.sv
// Shared definitions for the multi-port register file: stack-op encodings
// and default stack-pointer placement/bounds.
package reg_file_mp_pkg;

    typedef enum logic [1:0] {
        SOP_NONE = 2'b00,
        SOP_POP  = 2'b01,
        SOP_PUSH = 2'b10,
        SOP_RSVD = 2'b11
    } stack_op_t;

    localparam int          DEF_SP_IDX   = 29;
    localparam logic [31:0] DEF_SP_RESET = 32'h0000_1000;
    localparam logic [31:0] DEF_STACK_LO = 32'h0000_0800;
    localparam logic [31:0] DEF_STACK_HI = 32'h0000_1000;

endpackage

// File: rtl/reg_file_mp_sp_ctrl.sv
// Stack-pointer next-state logic: bounds-checked push/pop plus sticky
// overflow, underflow and reserved-op flags.
module reg_file_mp_sp_ctrl
    import reg_file_mp_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] SP_STEP  = 4,
    parameter logic [DATA_W-1:0] STACK_LO = DEF_STACK_LO[DATA_W-1:0],
    parameter logic [DATA_W-1:0] STACK_HI = DEF_STACK_HI[DATA_W-1:0]
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] sp_cur,
    input  logic [1:0]        stack_op,
    input  logic              sp_override,
    input  logic              clr_err,
    output logic [DATA_W-1:0] sp_next,
    output logic              sp_we,
    output logic              stack_ovf,
    output logic              stack_unf,
    output logic              bad_op
);

    // One extra bit catches wrap-around below zero or past the top of the range.
    logic [DATA_W:0] sp_dec;
    logic [DATA_W:0] sp_inc;
    logic            push_ok;
    logic            pop_ok;
    logic            set_ovf;
    logic            set_unf;
    logic            set_bad;

    assign sp_dec  = {1'b0, sp_cur} - {1'b0, SP_STEP};
    assign sp_inc  = {1'b0, sp_cur} + {1'b0, SP_STEP};
    assign push_ok = !sp_dec[DATA_W] && (sp_dec[DATA_W-1:0] >= STACK_LO);
    assign pop_ok  = (sp_inc <= {1'b0, STACK_HI});

    always_comb begin
        sp_next = sp_cur;
        sp_we   = 1'b0;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        set_bad = 1'b0;
        if (!sp_override) begin
            case (stack_op_t'(stack_op))
                SOP_PUSH: begin
                    if (push_ok) begin
                        sp_next = sp_dec[DATA_W-1:0];
                        sp_we   = 1'b1;
                    end else begin
                        set_ovf = 1'b1;
                    end
                end
                SOP_POP: begin
                    if (pop_ok) begin
                        sp_next = sp_inc[DATA_W-1:0];
                        sp_we   = 1'b1;
                    end else begin
                        set_unf = 1'b1;
                    end
                end
                SOP_RSVD: set_bad = 1'b1;
                default:  ;
            endcase
        end
    end

    // A fault in the same cycle as clr_err leaves the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            stack_ovf <= 1'b0;
            stack_unf <= 1'b0;
            bad_op    <= 1'b0;
        end else begin
            stack_ovf <= set_ovf | (stack_ovf & ~clr_err);
            stack_unf <= set_unf | (stack_unf & ~clr_err);
            bad_op    <= set_bad | (bad_op & ~clr_err);
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: NUM_RD combinational read ports, two write ports
// (wr1 wins on collision), hardwired r0 and a bounds-checked stack pointer.
module reg_file_mp
    import reg_file_mp_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 5,
    parameter int                NUM_RD   = 2,
    parameter int                SP_IDX   = DEF_SP_IDX,
    parameter logic [DATA_W-1:0] SP_STEP  = 4,
    parameter logic [DATA_W-1:0] SP_RESET = DEF_SP_RESET[DATA_W-1:0],
    parameter logic [DATA_W-1:0] STACK_LO = DEF_STACK_LO[DATA_W-1:0],
    parameter logic [DATA_W-1:0] STACK_HI = DEF_STACK_HI[DATA_W-1:0],
    parameter bit                BYPASS   = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     wr0_en,
    input  logic [ADDR_W-1:0]        wr0_addr,
    input  logic [DATA_W-1:0]        wr0_data,
    input  logic                     wr1_en,
    input  logic [ADDR_W-1:0]        wr1_addr,
    input  logic [DATA_W-1:0]        wr1_data,
    input  logic [1:0]               stack_op,
    input  logic                     clr_err,
    output logic [DATA_W-1:0]        sp_out,
    output logic                     stack_ovf,
    output logic                     stack_unf,
    output logic                     bad_op,
    output logic                     wr_conflict
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              wr0_live;
    logic              wr1_live;
    logic              sp_override;
    logic [DATA_W-1:0] sp_next;
    logic              sp_we;
    logic              wr_conflict_reg;

    // Writes aimed at r0 are discarded outright, so they never bypass or conflict.
    assign wr0_live    = wr0_en && (wr0_addr != '0);
    assign wr1_live    = wr1_en && (wr1_addr != '0);
    assign sp_override = (wr0_live && (wr0_addr == ADDR_W'(SP_IDX))) ||
                         (wr1_live && (wr1_addr == ADDR_W'(SP_IDX)));

    reg_file_mp_sp_ctrl #(
        .DATA_W   (DATA_W),
        .SP_STEP  (SP_STEP),
        .STACK_LO (STACK_LO),
        .STACK_HI (STACK_HI)
    ) u_sp_ctrl (
        .clk         (clk),
        .reset       (reset),
        .sp_cur      (regs[SP_IDX]),
        .stack_op    (stack_op),
        .sp_override (sp_override),
        .clr_err     (clr_err),
        .sp_next     (sp_next),
        .sp_we       (sp_we),
        .stack_ovf   (stack_ovf),
        .stack_unf   (stack_unf),
        .bad_op      (bad_op)
    );

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (reset) begin
                regs[i] <= (i == SP_IDX) ? SP_RESET : '0;
            end else if (i != 0) begin
                if (wr1_live && (wr1_addr == ADDR_W'(i)))
                    regs[i] <= wr1_data;
                else if (wr0_live && (wr0_addr == ADDR_W'(i)))
                    regs[i] <= wr0_data;
                else if ((i == SP_IDX) && sp_we)
                    regs[i] <= sp_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            wr_conflict_reg <= 1'b0;
        else
            wr_conflict_reg <= wr0_live && wr1_live && (wr0_addr == wr1_addr);
    end

    assign wr_conflict = wr_conflict_reg;
    assign sp_out      = regs[SP_IDX];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] addr;
            logic [DATA_W-1:0] stored;
            assign addr   = rd_addr[gi*ADDR_W +: ADDR_W];
            assign stored = (addr == '0) ? '0 : regs[addr];
            if (BYPASS) begin : g_byp
                // Stack-op SP updates are deliberately not forwarded.
                assign rd_data[gi*DATA_W +: DATA_W] =
                    (wr1_live && (wr1_addr == addr)) ? wr1_data :
                    (wr0_live && (wr0_addr == addr)) ? wr0_data : stored;
            end else begin : g_nobyp
                assign rd_data[gi*DATA_W +: DATA_W] = stored;
            end
        end
    endgenerate

endmodule
